// File: rtl/sum_responder.sv
// sum_responder: two request channels (A, B) share a credit-limited adder
// pipeline. Accepted operand pairs flow through two register stages into a
// response FIFO. Responses return in acceptance order with sum, carry and
// source channel.
module sum_responder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4   // power of two, 2 or greater
) (
    input  logic             clock,
    input  logic             rst_n,

    input  logic             sum_a_valid,
    output logic             sum_a_ready,
    input  logic [WIDTH-1:0] sum_a_a1,
    input  logic [WIDTH-1:0] sum_a_a2,

    input  logic             sum_b_valid,
    output logic             sum_b_ready,
    input  logic [WIDTH-1:0] sum_b_b1,
    input  logic [WIDTH-1:0] sum_b_b2,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_carry,
    output logic             resp_src
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] sum;
        src_e             src;
    } resp_t;

    // ------------------------------------------------------------------
    // Credit, arbitration and handshake signals
    // ------------------------------------------------------------------
    logic [CW-1:0] outstanding;
    logic          space;
    src_e          last_grant;
    logic          grant_a;
    logic          grant_b;
    logic          accept_a;
    logic          accept_b;
    logic          accept;
    logic          pop;

    // Pipeline stages
    logic             s1_valid;
    logic [WIDTH-1:0] s1_op1;
    logic [WIDTH-1:0] s1_op2;
    src_e             s1_src;
    logic [WIDTH:0]   s1_total;

    logic  s2_valid;
    resp_t s2_entry;

    // Response FIFO
    resp_t         fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    resp_t         head;

    // Space comes from the registered count only; a pop this cycle frees a
    // slot starting next cycle.
    assign space = (outstanding < DEPTH_CNT);

    // Round-robin arbiter: a lone requester wins, contention goes to the
    // channel that did not win last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first
        // so no path leaves it unassigned and a latch cannot be inferred.
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (sum_a_valid && sum_b_valid) begin
            if (last_grant == SRC_B) begin
                grant_a = 1'b1;
            end else begin
                grant_b = 1'b1;
            end
        end else begin
            grant_a = sum_a_valid;
            grant_b = sum_b_valid;
        end
    end

    assign sum_a_ready = space & grant_a;
    assign sum_b_ready = space & grant_b;

    assign accept_a = sum_a_valid & sum_a_ready;
    assign accept_b = sum_b_valid & sum_b_ready;
    assign accept   = accept_a | accept_b;
    assign pop      = resp_valid & resp_ready;

    // Outstanding-request credit counter: accept adds, pop removes.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Remember the winner of the last accept; reset favours A next.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            last_grant <= SRC_B;
        end else if (accept_b) begin
            last_grant <= SRC_B;
        end else if (accept_a) begin
            last_grant <= SRC_A;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture accepted operands and source
    // ------------------------------------------------------------------

    // Stage 1 valid bit; cleared by reset so in-flight work is discarded.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
    end

    // Stage 1 payload, qualified by s1_valid so it needs no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            s1_op1 <= accept_b ? sum_b_b1 : sum_a_a1;
            s1_op2 <= accept_b ? sum_b_b2 : sum_a_a2;
            s1_src <= accept_b ? SRC_B : SRC_A;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: add and register the response entry
    // ------------------------------------------------------------------
    assign s1_total = {1'b0, s1_op1} + {1'b0, s1_op2};

    // Stage 2 valid bit follows stage 1; the pipeline never stalls.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
    end

    // Stage 2 payload: carry is the top bit of the widened sum.
    always_ff @(posedge clock) begin
        if (s1_valid) begin
            s2_entry.carry <= s1_total[WIDTH];
            s2_entry.sum   <= s1_total[WIDTH-1:0];
            s2_entry.src   <= s1_src;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO. Credits guarantee a free slot for every write, so the
    // write side has no full check.
    // ------------------------------------------------------------------

    // FIFO storage write port.
    always_ff @(posedge clock) begin
        // NOTE: the storage array is deliberately not reset; the pointers
        // and count decide which entries are meaningful.
        if (s2_valid) begin
            fifo_mem[wr_ptr] <= s2_entry;
        end
    end

    // FIFO pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (s2_valid) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // FIFO occupancy; a write and a pop in the same cycle cancel out.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            fifo_count <= '0;
        end else begin
            case ({s2_valid, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign head       = fifo_mem[rd_ptr];
    assign resp_valid = (fifo_count != '0);

    // Present the head entry while valid, zeros otherwise.
    always_comb begin
        resp_sum   = '0;
        resp_carry = 1'b0;
        resp_src   = 1'b0;
        if (resp_valid) begin
            resp_sum   = head.sum;
            resp_carry = head.carry;
            resp_src   = head.src;
        end
    end

endmodule

// File: tb/tb_sum_responder.sv
// Self-checking bench for sum_responder. A queue-based model tracks every
// outstanding request with the cycle at which its response becomes visible;
// the DUT is compared against it every cycle.
module tb_sum_responder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clock;
    logic             rst_n;
    logic             sum_a_valid;
    logic             sum_a_ready;
    logic [WIDTH-1:0] sum_a_a1;
    logic [WIDTH-1:0] sum_a_a2;
    logic             sum_b_valid;
    logic             sum_b_ready;
    logic [WIDTH-1:0] sum_b_b1;
    logic [WIDTH-1:0] sum_b_b2;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_sum;
    logic             resp_carry;
    logic             resp_src;

    sum_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .sum_a_valid (sum_a_valid),
        .sum_a_ready (sum_a_ready),
        .sum_a_a1    (sum_a_a1),
        .sum_a_a2    (sum_a_a2),
        .sum_b_valid (sum_b_valid),
        .sum_b_ready (sum_b_ready),
        .sum_b_b1    (sum_b_b1),
        .sum_b_b2    (sum_b_b2),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_sum    (resp_sum),
        .resp_carry  (resp_carry),
        .resp_src    (resp_src)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int sum;
        int carry;
        int src;
        int vis;   // first cycle index at which the response is visible
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   last_b   = 1;   // model of "last grant was B"
    int   total    = 0;
    int   bad      = 0;
    int   dut_acc  = 0;   // handshakes observed on the DUT pins
    int   pops     = 0;   // responses popped according to the model

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare against the
    // model, then advance the model across the rising edge.
    task automatic tick(input logic rst, input logic av, input int a1, input int a2,
                        input logic bv, input int b1, input int b2, input logic rr);
        int   e_ar, e_br, e_rv, ga, gb, pop_e, acc_e, s;
        exp_t e;
        rst_n       = rst;
        sum_a_valid = av;
        sum_a_a1    = WIDTH'(a1);
        sum_a_a2    = WIDTH'(a2);
        sum_b_valid = bv;
        sum_b_b1    = WIDTH'(b1);
        sum_b_b2    = WIDTH'(b2);
        resp_ready  = rr;
        #1;
        pop_e = 0;
        acc_e = 0;
        e_br  = 0;
        if (rst) begin
            ga   = av && (!bv || last_b == 1);
            gb   = bv && (!av || last_b == 0);
            e_ar = (q.size() < DEPTH) && ga;
            e_br = (q.size() < DEPTH) && gb;
            e_rv = (q.size() > 0) && (q[0].vis <= cyc);
            check("a_ready", 32'(sum_a_ready), 32'(e_ar));
            check("b_ready", 32'(sum_b_ready), 32'(e_br));
            check("resp_valid", 32'(resp_valid), 32'(e_rv));
            if (e_rv != 0) begin
                check("resp_sum", 32'(resp_sum), 32'(q[0].sum));
                check("resp_carry", 32'(resp_carry), 32'(q[0].carry));
                check("resp_src", 32'(resp_src), 32'(q[0].src));
            end else begin
                check("idle_sum", 32'(resp_sum), 32'd0);
                check("idle_carry", 32'(resp_carry), 32'd0);
                check("idle_src", 32'(resp_src), 32'd0);
            end
            if ((sum_a_valid && sum_a_ready) || (sum_b_valid && sum_b_ready)) dut_acc++;
            pop_e = e_rv && rr;
            acc_e = (e_ar && av) || (e_br && bv);
        end
        @(posedge clock);
        cyc++;
        if (!rst) begin
            q.delete();
            last_b = 1;
        end else begin
            if (pop_e != 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (acc_e != 0) begin
                s       = (e_br != 0) ? (b1 + b2) : (a1 + a2);
                e.sum   = s % 256;
                e.carry = (s >= 256) ? 1 : 0;
                e.src   = (e_br != 0) ? 1 : 0;
                e.vis   = cyc + 2;
                q.push_back(e);
                last_b  = e.src;
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, rr);
    endtask

    initial begin
        int p0;
        rst_n       = 1'b0;
        sum_a_valid = 1'b0;
        sum_b_valid = 1'b0;
        sum_a_a1    = '0;
        sum_a_a2    = '0;
        sum_b_b1    = '0;
        sum_b_b2    = '0;
        resp_ready  = 1'b0;
        @(negedge clock);

        // Reset, with a request presented that must be ignored.
        tick(1'b0, 1'b1, 9, 9, 1'b0, 0, 0, 1'b1);
        tick(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        idle(2, 1'b1);

        // Single A request 1+2: valid two cycles after accept.
        tick(1'b1, 1'b1, 1, 2, 1'b0, 0, 0, 1'b1);
        tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        check("lat_not_yet", 32'(resp_valid), 32'd0);
        tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        check("lat_sum3", 32'(resp_sum), 32'd3);
        idle(2, 1'b1);

        // Overflowing B request 200+100 -> 44 with carry.
        tick(1'b1, 1'b0, 0, 0, 1'b1, 200, 100, 1'b1);
        tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        check("ovf_sum44", 32'(resp_sum), 32'd44);
        check("ovf_carry", 32'(resp_carry), 32'd1);
        idle(2, 1'b1);

        // Contention for 4 cycles: grants alternate A, B, A, B.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 10 + i, 20, 1'b1, 100 + i, 200, 1'b1);
        idle(6, 1'b1);

        // Backpressure: exactly DEPTH accepts, then drain with readies back.
        dut_acc = 0;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, i, 3 * i, 1'b1, 250, i, 1'b0);
        check("fill_accepts", 32'(dut_acc), 32'(DEPTH));
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 7, i, 1'b1, 128, 128 + i, 1'b1);
        idle(8, 1'b1);

        // Reset pulse with 3 outstanding: nothing emerges, A wins next.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 40 + i, 1, 1'b0, 0, 0, 1'b0);
        tick(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        idle(3, 1'b1);
        tick(1'b1, 1'b1, 5, 6, 1'b1, 7, 8, 1'b1);
        idle(4, 1'b1);

        // Full buffer then sustained traffic: 16 transactions, one per cycle.
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 60 + i, 190, 1'b0, 0, 0, 1'b0);
        p0 = pops;
        for (int i = 0; i < 16; i++)
            tick(1'b1, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
                 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
        check("sustain_pops", 32'(pops - p0), 32'd16);
        idle(8, 1'b1);
        check("drained", 32'(q.size()), 32'd0);

        // Random traffic with random backpressure and occasional reset.
        for (int i = 0; i < 400; i++)
            tick(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) != 0),
                 $urandom_range(0, 255), $urandom_range(0, 255),
                 ($urandom_range(0, 1) != 0), $urandom_range(0, 255), $urandom_range(0, 255),
                 ($urandom_range(0, 3) != 0));
        idle(10, 1'b1);
        check("final_empty", 32'(resp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
